fp_seq: RTL

FP_SEQ -- requirements
Module: fp_seq

---
 rtl/fp_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_seq.sv
// fp_seq: floating-point micro-sequencer.
// Walks an FP instruction through states F1..F13. Every state lasts four
// clocks (phases P0..P3) and branches at the end of P3. F8 (alignment) and
// F10 (multiply/divide) are loop states bounded by LOOP_MAX iterations.
// Fault requests sampled in P3 abort the instruction. All outputs are registered.

module fp_seq #(
  parameter int LOOP_MAX = 80
) (
  input  logic       __clk,
  input  logic       _0_f_,
  input  logic       start,
  input  logic       af_sf,
  input  logic       mw_mf,
  input  logic       dw_df,
  input  logic       ff,
  input  logic       fic,
  input  logic       g,
  input  logic       wt,
  input  logic       fi0_,
  input  logic       fi1_,
  input  logic       fi2_,
  input  logic       fi3_,
  output logic       f2_,
  output logic       f4_,
  output logic       f5_,
  output logic       f6_,
  output logic       f7_,
  output logic       f8_,
  output logic       f10_,
  output logic       f9,
  output logic       f13,
  output logic       strob_fp_,
  output logic       strob2_fp,
  output logic [3:0] fstate,
  output logic       busy,
  output logic       done,
  output logic [4:0] err
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F1   = 4'd1,
    S_F2   = 4'd2,
    S_F4   = 4'd4,
    S_F5   = 4'd5,
    S_F6   = 4'd6,
    S_F7   = 4'd7,
    S_F8   = 4'd8,
    S_F9   = 4'd9,
    S_F10  = 4'd10,
    S_F13  = 4'd13
  } state_t;

  localparam logic [6:0] LOOP_LIM = 7'(LOOP_MAX);

  state_t     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [6:0] loop_q, loop_d;
  logic [4:0] err_q, err_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       strob_q, strob_d;
  logic       strob2_q, strob2_d;
  logic [6:0] fl_q, fl_d;
  logic       f9_q, f9_d;
  logic       f13_q, f13_d;

  logic [3:0] fault;
  logic [6:0] loop_inc;
  logic       loop_hit;

  // wt is reserved for a future F4 extension and does not steer sequencing
  logic unused_wt;
  assign unused_wt = wt;

  assign fault    = ~{fi0_, fi1_, fi2_, fi3_};
  assign loop_inc = loop_q + 7'd1;
  assign loop_hit = (loop_inc >= LOOP_LIM);

  // Next-state, phase, loop counter, fault latch and registered output values
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    loop_d  = loop_q;
    err_d   = err_q;
    done_d  = 1'b0;

    if (state_q == S_IDLE) begin
      phase_d = 2'd0;
      if (start) begin
        state_d = S_F1;
        err_d   = 5'd0;
      end
    end else if (phase_q != 2'd3) begin
      phase_d = phase_q + 2'd1;
    end else begin
      phase_d = 2'd0;
      if (|fault) begin
        state_d = S_IDLE;
        err_d   = err_q | {1'b0, fault};
        done_d  = 1'b1;
      end else begin
        case (state_q)
          S_F1:  state_d = S_F2;
          S_F2:  state_d = af_sf ? S_F5 : S_F4;
          S_F5: begin
            if (g || !fic) begin
              state_d = S_F4;
            end else begin
              state_d = S_F8;
              loop_d  = 7'd0;
            end
          end
          S_F8: begin
            loop_d = loop_inc;
            if (!fic) begin
              state_d = S_F4;
            end else if (loop_hit) begin
              state_d  = S_F4;
              err_d[4] = 1'b1;
            end
          end
          S_F4: begin
            if (mw_mf || dw_df) begin
              state_d = S_F10;
              loop_d  = 7'd0;
            end else begin
              state_d = S_F6;
            end
          end
          S_F10: begin
            loop_d = loop_inc;
            if (!fic) begin
              state_d = S_F6;
            end else if (loop_hit) begin
              state_d  = S_F6;
              err_d[4] = 1'b1;
            end
          end
          S_F6:  state_d = S_F7;
          S_F7:  state_d = ff ? S_F13 : S_F9;
          S_F13: state_d = S_F9;
          S_F9: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    busy_d   = (state_d != S_IDLE);
    strob_d  = !(busy_d && (phase_d == 2'd1));
    strob2_d = busy_d && (phase_d == 2'd3);
    fl_d     = ~{state_d == S_F2, state_d == S_F4, state_d == S_F5, state_d == S_F6,
                 state_d == S_F7, state_d == S_F8, state_d == S_F10};
    f9_d     = (state_d == S_F9);
    f13_d    = (state_d == S_F13);
  end

  // Sequencer register: state, phase, loop count and all registered outputs
  always_ff @(posedge __clk or negedge _0_f_) begin
    if (!_0_f_) begin
      state_q  <= S_IDLE;
      phase_q  <= 2'd0;
      loop_q   <= 7'd0;
      err_q    <= 5'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      strob_q  <= 1'b1;
      strob2_q <= 1'b0;
      fl_q     <= 7'h7F;
      f9_q     <= 1'b0;
      f13_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      loop_q   <= loop_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      strob_q  <= strob_d;
      strob2_q <= strob2_d;
      fl_q     <= fl_d;
      f9_q     <= f9_d;
      f13_q    <= f13_d;
    end
  end

  assign {f2_, f4_, f5_, f6_, f7_, f8_, f10_} = fl_q;
  assign f9        = f9_q;
  assign f13       = f13_q;
  assign strob_fp_ = strob_q;
  assign strob2_fp = strob2_q;
  assign fstate    = state_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
